// File: rtl/hazard_ctrl_md_pkg.sv
// Shared encodings for the hazard controller: operand-use and result-ready stage distances.
package hazard_ctrl_md_pkg;

  localparam logic [1:0] TUSE_D    = 2'd0;
  localparam logic [1:0] TUSE_E    = 2'd1;
  localparam logic [1:0] TUSE_M    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_READY = 2'd0;
  localparam logic [1:0] TNEW_1     = 2'd1;
  localparam logic [1:0] TNEW_2     = 2'd2;
  localparam logic [1:0] TNEW_3     = 2'd3;

  // Busy-cycle count for an issued multiply/divide.
  function automatic int md_load_value(input logic is_div, input int mult_lat, input int div_lat);
    return is_div ? div_lat : mult_lat;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_md_busy.sv
// Tracks occupancy of the sequential multiply/divide unit as a down-counter.
module md_busy_tracker
  import hazard_ctrl_md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int CW = $clog2(DIV_LAT + 1);

  logic [CW-1:0] count;

  // A start while already counting reloads; the most recent operation wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(md_load_value(is_div, MULT_LAT, DIV_LAT));
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl_md.sv
// Pipeline hazard controller: Tuse/Tnew stall detection, forwarding muxes,
// multiply/divide occupancy stall and a saturating stall-cycle counter.
module hazard_ctrl_md
  import hazard_ctrl_md_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_A1,
  input  logic [REG_AW-1:0] D_A2,
  input  logic [1:0]        D_rs_tuse,
  input  logic [1:0]        D_rt_tuse,
  input  logic [DATA_W-1:0] D_RD1,
  input  logic [DATA_W-1:0] D_RD2,
  input  logic              D_is_md,
  input  logic [REG_AW-1:0] E_A1,
  input  logic [REG_AW-1:0] E_A2,
  input  logic [REG_AW-1:0] E_A3,
  input  logic [1:0]        E_tnew,
  input  logic [DATA_W-1:0] E_RD1,
  input  logic [DATA_W-1:0] E_RD2,
  input  logic [DATA_W-1:0] E_WD,
  input  logic              E_md_start,
  input  logic              E_md_div,
  input  logic [REG_AW-1:0] M_A2,
  input  logic [REG_AW-1:0] M_A3,
  input  logic [DATA_W-1:0] M_RD2,
  input  logic [DATA_W-1:0] M_WD,
  input  logic [1:0]        M_tnew,
  input  logic [REG_AW-1:0] W_A3,
  input  logic [DATA_W-1:0] W_WD,
  output logic [DATA_W-1:0] D_Forward1,
  output logic [DATA_W-1:0] D_Forward2,
  output logic [DATA_W-1:0] E_Forward1,
  output logic [DATA_W-1:0] E_Forward2,
  output logic [DATA_W-1:0] M_Forward2,
  output logic              F_en,
  output logic              D_pipereg_en,
  output logic              E_pipereg_flush,
  output logic              md_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic stall_rs, stall_rt, md_stall, stall;

  // Register 0 is hard-wired zero, so it never matches a producer.
  function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

  function automatic logic data_stall(input logic [REG_AW-1:0] src, input logic [1:0] tuse);
    return (tuse != TUSE_NONE) &&
           ((hit(src, E_A3) && (tuse < E_tnew)) || (hit(src, M_A3) && (tuse < M_tnew)));
  endfunction

  // An E producer not yet ready falls through; the stall keeps the stale value unused.
  function automatic logic [DATA_W-1:0] fwd_d(input logic [REG_AW-1:0] src,
                                              input logic [DATA_W-1:0] grf);
    if (hit(src, E_A3) && (E_tnew == TNEW_READY)) return E_WD;
    else if (hit(src, M_A3) && (M_tnew == TNEW_READY)) return M_WD;
    else return grf;
  endfunction

  function automatic logic [DATA_W-1:0] fwd_e(input logic [REG_AW-1:0] src,
                                              input logic [DATA_W-1:0] held);
    if (hit(src, M_A3) && (M_tnew == TNEW_READY)) return M_WD;
    else if (hit(src, W_A3)) return W_WD;
    else return held;
  endfunction

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy (
    .clk    (clk),
    .reset  (reset),
    .start  (E_md_start),
    .is_div (E_md_div),
    .busy   (md_busy)
  );

  always_comb begin
    stall_rs = data_stall(D_A1, D_rs_tuse);
    stall_rt = data_stall(D_A2, D_rt_tuse);
    md_stall = D_is_md && (md_busy || E_md_start);
    stall    = stall_rs || stall_rt || md_stall;
  end

  assign F_en            = !stall;
  assign D_pipereg_en    = !stall;
  assign E_pipereg_flush = stall;

  always_comb begin
    D_Forward1 = fwd_d(D_A1, D_RD1);
    D_Forward2 = fwd_d(D_A2, D_RD2);
    E_Forward1 = fwd_e(E_A1, E_RD1);
    E_Forward2 = fwd_e(E_A2, E_RD2);
    M_Forward2 = hit(M_A2, W_A3) ? W_WD : M_RD2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_md.sv
// Self-checking bench for hazard_ctrl_md: vector table, multi-cycle sequences, random vs model.
`timescale 1ns/1ps
module tb_hazard_ctrl_md;

  localparam logic [31:0] RD1 = 32'hD1, RD2 = 32'hD2, ERD1 = 32'hE1, ERD2 = 32'hE2;
  localparam logic [31:0] MRD2 = 32'hA2, EWD = 32'h11, MWD = 32'h22, WWD = 32'h33;

  logic clk = 1'b0;
  logic reset;
  logic [4:0]  D_A1, D_A2, E_A1, E_A2, E_A3, M_A2, M_A3, W_A3;
  logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic [31:0] D_RD1, D_RD2, E_RD1, E_RD2, E_WD, M_RD2, M_WD, W_WD;
  logic        D_is_md, E_md_start, E_md_div;
  logic [31:0] D_Forward1, D_Forward2, E_Forward1, E_Forward2, M_Forward2, stall_cnt;
  logic        F_en, D_pipereg_en, E_pipereg_flush, md_busy;
  logic [31:0] s_df1, s_df2, s_ef1, s_ef2, s_mf2;
  logic        s_fen, s_den, s_flush, s_busy;
  logic [3:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_md dut (
    .clk(clk), .reset(reset), .D_A1(D_A1), .D_A2(D_A2), .D_rs_tuse(D_rs_tuse),
    .D_rt_tuse(D_rt_tuse), .D_RD1(D_RD1), .D_RD2(D_RD2), .D_is_md(D_is_md),
    .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_tnew(E_tnew), .E_RD1(E_RD1), .E_RD2(E_RD2),
    .E_WD(E_WD), .E_md_start(E_md_start), .E_md_div(E_md_div), .M_A2(M_A2), .M_A3(M_A3),
    .M_RD2(M_RD2), .M_WD(M_WD), .M_tnew(M_tnew), .W_A3(W_A3), .W_WD(W_WD),
    .D_Forward1(D_Forward1), .D_Forward2(D_Forward2), .E_Forward1(E_Forward1),
    .E_Forward2(E_Forward2), .M_Forward2(M_Forward2), .F_en(F_en),
    .D_pipereg_en(D_pipereg_en), .E_pipereg_flush(E_pipereg_flush), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  hazard_ctrl_md #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .D_A1(D_A1), .D_A2(D_A2), .D_rs_tuse(D_rs_tuse),
    .D_rt_tuse(D_rt_tuse), .D_RD1(D_RD1), .D_RD2(D_RD2), .D_is_md(D_is_md),
    .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_tnew(E_tnew), .E_RD1(E_RD1), .E_RD2(E_RD2),
    .E_WD(E_WD), .E_md_start(E_md_start), .E_md_div(E_md_div), .M_A2(M_A2), .M_A3(M_A3),
    .M_RD2(M_RD2), .M_WD(M_WD), .M_tnew(M_tnew), .W_A3(W_A3), .W_WD(W_WD),
    .D_Forward1(s_df1), .D_Forward2(s_df2), .E_Forward1(s_ef1),
    .E_Forward2(s_ef2), .M_Forward2(s_mf2), .F_en(s_fen),
    .D_pipereg_en(s_den), .E_pipereg_flush(s_flush), .md_busy(s_busy),
    .stall_cnt(s_cnt)
  );

  typedef struct {
    logic [4:0] d_a1, d_a2; logic [1:0] rs_tuse, rt_tuse; logic is_md;
    logic [4:0] e_a1, e_a2, e_a3; logic [1:0] e_tnew;
    logic [4:0] m_a2, m_a3; logic [1:0] m_tnew; logic [4:0] w_a3;
    logic stall; logic [31:0] df1, df2, ef1, ef2, mf2;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    D_A1 = 0; D_A2 = 0; D_rs_tuse = 3; D_rt_tuse = 3; D_is_md = 0;
    E_A1 = 0; E_A2 = 0; E_A3 = 0; E_tnew = 0; E_md_start = 0; E_md_div = 0;
    M_A2 = 0; M_A3 = 0; M_tnew = 0; W_A3 = 0;
    D_RD1 = RD1; D_RD2 = RD2; E_RD1 = ERD1; E_RD2 = ERD2; M_RD2 = MRD2;
    E_WD = EWD; M_WD = MWD; W_WD = WWD;
  endtask

  // Reference: a consumer stalls if it needs the operand sooner than the producer can deliver it.
  function automatic logic model_stall(input logic [4:0] src, input logic [1:0] tuse);
    int need_in;
    int ready_in[2];
    logic [4:0] dst[2];
    if (src == 0 || tuse == 3) return 1'b0;
    need_in = tuse;
    dst[0] = E_A3; ready_in[0] = E_tnew;
    dst[1] = M_A3; ready_in[1] = M_tnew;
    for (int i = 0; i < 2; i++)
      if (dst[i] == src && ready_in[i] > need_in) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: scan producers nearest-first; the first one holding src with a ready value wins.
  function automatic logic [31:0] model_fwd(input logic [4:0] src, input int n,
                                            input logic [4:0] dst[3], input logic rdy[3],
                                            input logic [31:0] val[3], input logic [31:0] dflt);
    if (src == 0) return dflt;
    for (int i = 0; i < n; i++)
      if (dst[i] == src && rdy[i]) return val[i];
    return dflt;
  endfunction

  task automatic check_comb(input string tag, input logic exp_stall, input logic [31:0] df1,
                            input logic [31:0] df2, input logic [31:0] ef1,
                            input logic [31:0] ef2, input logic [31:0] mf2);
    chk({tag, " F_en"}, F_en, !exp_stall);
    chk({tag, " D_pipereg_en"}, D_pipereg_en, !exp_stall);
    chk({tag, " E_flush"}, E_pipereg_flush, exp_stall);
    chk({tag, " D_Forward1"}, D_Forward1, df1);
    chk({tag, " D_Forward2"}, D_Forward2, df2);
    chk({tag, " E_Forward1"}, E_Forward1, ef1);
    chk({tag, " E_Forward2"}, E_Forward2, ef2);
    chk({tag, " M_Forward2"}, M_Forward2, mf2);
  endtask

  task automatic md_sequence(input logic is_div, input int lat);
    logic [31:0] cnt0;
    int busy_n, stall_n;
    clear_inputs();
    cnt0 = stall_cnt;
    E_md_start = 1; E_md_div = is_div;
    #2;
    chk(is_div ? "div busy before edge" : "mult busy before edge", md_busy, 1'b0);
    tick();
    E_md_start = 0; E_md_div = 0; D_is_md = 1;
    busy_n = 0; stall_n = 0;
    for (int i = 0; i < 20; i++) begin
      #2;
      if (md_busy) busy_n++;
      if (!F_en) stall_n++;
      tick();
    end
    chk(is_div ? "div busy cycles" : "mult busy cycles", busy_n, lat);
    chk(is_div ? "div stall cycles" : "mult stall cycles", stall_n, lat);
    chk(is_div ? "div stall_cnt delta" : "mult stall_cnt delta", stall_cnt - cnt0, lat);
    D_is_md = 0;
  endtask

  initial begin
    int md_left;
    longint cnt;
    logic e_stall;
    logic [4:0] dd[3];
    logic rr[3];
    logic [31:0] vv[3];
    logic [31:0] x_df1, x_df2, x_ef1, x_ef2, x_mf2;

    vecs[0]  = '{8,0,1,3,0, 0,0,8,2, 0,0,0,0, 1, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[1]  = '{8,0,1,3,0, 0,0,0,0, 0,8,1,0, 0, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[2]  = '{5,5,0,0,0, 5,5,5,0, 5,5,0,5, 0, EWD,EWD,MWD,MWD,WWD};
    vecs[3]  = '{5,5,0,0,0, 5,5,0,0, 5,0,0,0, 0, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[4]  = '{3,0,0,3,0, 0,0,0,0, 0,3,1,0, 1, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[5]  = '{3,0,0,3,0, 0,0,0,0, 0,3,0,0, 0, MWD,RD2,ERD1,ERD2,MRD2};
    vecs[6]  = '{0,0,1,3,0, 0,0,0,2, 0,0,0,0, 0, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[7]  = '{6,0,3,3,0, 0,0,6,2, 0,0,0,0, 0, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[8]  = '{0,7,3,1,0, 0,0,0,0, 0,7,2,0, 1, RD1,RD2,ERD1,ERD2,MRD2};
    vecs[9]  = '{4,0,1,3,0, 0,0,4,1, 0,4,0,0, 0, MWD,RD2,ERD1,ERD2,MRD2};
    vecs[10] = '{0,0,3,3,0, 9,0,0,0, 0,9,1,9, 0, RD1,RD2,WWD,ERD2,MRD2};
    vecs[11] = '{0,0,3,3,1, 0,0,0,0, 9,0,0,9, 0, RD1,RD2,ERD1,ERD2,WWD};

    clear_inputs();
    reset = 0;
    #12;
    chk("reset md_busy", md_busy, 1'b0);
    chk("reset stall_cnt", stall_cnt, 32'd0);
    reset = 1;
    tick();

    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      D_A1 = vecs[i].d_a1; D_A2 = vecs[i].d_a2;
      D_rs_tuse = vecs[i].rs_tuse; D_rt_tuse = vecs[i].rt_tuse; D_is_md = vecs[i].is_md;
      E_A1 = vecs[i].e_a1; E_A2 = vecs[i].e_a2; E_A3 = vecs[i].e_a3; E_tnew = vecs[i].e_tnew;
      M_A2 = vecs[i].m_a2; M_A3 = vecs[i].m_a3; M_tnew = vecs[i].m_tnew; W_A3 = vecs[i].w_a3;
      #2;
      check_comb($sformatf("vec%0d", i), vecs[i].stall, vecs[i].df1, vecs[i].df2,
                 vecs[i].ef1, vecs[i].ef2, vecs[i].mf2);
      tick();
    end

    md_sequence(1'b1, 10);
    md_sequence(1'b0, 5);

    // Async reset in the middle of a divide.
    clear_inputs();
    E_md_start = 1; E_md_div = 1;
    tick();
    E_md_start = 0; E_md_div = 0; D_is_md = 1;
    tick(); tick();
    #2;
    chk("pre-reset md_busy", md_busy, 1'b1);
    chk("pre-reset stall_cnt nonzero", stall_cnt != 0, 1'b1);
    reset = 0;
    #1;
    chk("async reset md_busy", md_busy, 1'b0);
    chk("async reset stall_cnt", stall_cnt, 32'd0);
    chk("async reset sat stall_cnt", s_cnt, 4'd0);
    chk("in-reset md no stall", F_en, 1'b1);
    D_A1 = 8; D_rs_tuse = 1; E_A3 = 8; E_tnew = 2;
    #1;
    chk("in-reset load-use stall", F_en, 1'b0);
    tick();
    chk("held reset stall_cnt", stall_cnt, 32'd0);
    clear_inputs();
    reset = 1;
    tick();

    // Random stimulus against the reference model.
    md_left = 0;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      D_A1 = 5'($urandom_range(0, 3)); D_A2 = 5'($urandom_range(0, 3));
      D_rs_tuse = 2'($urandom); D_rt_tuse = 2'($urandom);
      D_is_md = ($urandom_range(0, 2) == 0);
      E_A1 = 5'($urandom_range(0, 3)); E_A2 = 5'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3)); E_tnew = 2'($urandom_range(0, 2));
      E_md_start = ($urandom_range(0, 7) == 0); E_md_div = 1'($urandom);
      M_A2 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
      M_tnew = 2'($urandom_range(0, 1)); W_A3 = 5'($urandom_range(0, 3));
      D_RD1 = $urandom; D_RD2 = $urandom; E_RD1 = $urandom; E_RD2 = $urandom;
      M_RD2 = $urandom; E_WD = $urandom; M_WD = $urandom; W_WD = $urandom;

      e_stall = model_stall(D_A1, D_rs_tuse) || model_stall(D_A2, D_rt_tuse) ||
                (D_is_md && (md_left > 0 || E_md_start));
      dd[0] = E_A3; rr[0] = (E_tnew == 0); vv[0] = E_WD;
      dd[1] = M_A3; rr[1] = (M_tnew == 0); vv[1] = M_WD;
      dd[2] = 0;    rr[2] = 1'b0;          vv[2] = 0;
      x_df1 = model_fwd(D_A1, 2, dd, rr, vv, D_RD1);
      x_df2 = model_fwd(D_A2, 2, dd, rr, vv, D_RD2);
      dd[0] = M_A3; rr[0] = (M_tnew == 0); vv[0] = M_WD;
      dd[1] = W_A3; rr[1] = 1'b1;          vv[1] = W_WD;
      x_ef1 = model_fwd(E_A1, 2, dd, rr, vv, E_RD1);
      x_ef2 = model_fwd(E_A2, 2, dd, rr, vv, E_RD2);
      dd[0] = W_A3; rr[0] = 1'b1; vv[0] = W_WD;
      x_mf2 = model_fwd(M_A2, 1, dd, rr, vv, M_RD2);
      #2;
      check_comb($sformatf("rnd%0d", c), e_stall, x_df1, x_df2, x_ef1, x_ef2, x_mf2);
      chk($sformatf("rnd%0d md_busy", c), md_busy, md_left > 0);
      chk($sformatf("rnd%0d stall_cnt", c), stall_cnt, cnt[31:0]);
      chk($sformatf("rnd%0d sat stall_cnt", c), s_cnt, (cnt > 15) ? 4'd15 : 4'(cnt));
      if (e_stall) cnt++;
      if (E_md_start) md_left = E_md_div ? 10 : 5;
      else if (md_left > 0) md_left--;
      tick();
    end
    chk("sat counter reached ceiling", s_cnt, (cnt > 15) ? 4'd15 : 4'(cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
